// File: rtl/mem_access_stage.sv
// Pipeline memory stage: drives a 1-cycle-latency word memory, extracts/extends loads,
// merges store-byte via read-modify-write, and holds the MEM/WB register.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       mem_wd_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_data_sel_i,
  input  logic [4:0]        wr_i,
  input  logic [1:0]        wd_sel_i,
  input  logic              regfile_we_i,
  input  logic [31:0]       return_pc_i,
  input  logic [31:0]       current_pc_i,
  input  logic              is_sb_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_re_o,
  output logic              dmem_we_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       wb_data_o,
  output logic [4:0]        wr_o,
  output logic              regfile_we_o,
  output logic [31:0]       current_pc_o
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, SB_MERGE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] wb_data_reg, current_pc_reg;
  logic [4:0]  wr_reg;
  logic        regfile_we_reg;

  logic [1:0]  off;
  logic [31:0] word_addr;
  logic [31:0] merged_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] wb_mux;
  logic        re_next, we_next, stall_next, bubble_next;
  logic [31:0] wdata_next;

  assign off         = alu_result_i[1:0];
  assign word_addr   = {alu_result_i[31:2], 2'b00};
  assign dmem_addr_o = word_addr[ADDR_W-1:0];

  // Store-byte merge: replace only the addressed lane of the word just read.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
      assign merged_word[8*gi +: 8] = (off == gi[1:0]) ? mem_wd_i[7:0]
                                                       : dmem_rdata_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    lane_byte = dmem_rdata_i[{off, 3'b000} +: 8];
    lane_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (mem_data_sel_i)
      2'b00:   load_data = dmem_rdata_i;
      2'b01:   load_data = {{24{lane_byte[7]}}, lane_byte};
      2'b10:   load_data = {24'h000000, lane_byte};
      default: load_data = {{16{lane_half[15]}}, lane_half};
    endcase
  end

  always_comb begin
    case (wd_sel_i)
      2'b01:   wb_mux = load_data;
      2'b10:   wb_mux = return_pc_i;
      default: wb_mux = alu_result_i;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    re_next     = 1'b0;
    we_next     = 1'b0;
    stall_next  = 1'b0;
    bubble_next = 1'b0;
    wdata_next  = mem_wd_i;
    case (state_reg)
      IDLE: begin
        if (mem_we_i) begin
          if (is_sb_i) begin
            re_next     = 1'b1;
            stall_next  = 1'b1;
            bubble_next = 1'b1;
            state_next  = SB_MERGE;
          end else begin
            we_next = 1'b1;
          end
        end else if (wd_sel_i == 2'b01) begin
          re_next     = 1'b1;
          stall_next  = 1'b1;
          bubble_next = 1'b1;
          state_next  = LOAD_WAIT;
        end
      end
      LOAD_WAIT: state_next = IDLE;
      SB_MERGE: begin
        we_next    = 1'b1;
        wdata_next = merged_word;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset suppresses strobes combinationally so an aborted read-modify-write never writes.
  assign dmem_re_o    = re_next & rst_n_i;
  assign dmem_we_o    = we_next & rst_n_i;
  assign stall_o      = stall_next & rst_n_i;
  assign dmem_wdata_o = wdata_next;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      wb_data_reg    <= 32'h0;
      wr_reg         <= 5'd0;
      regfile_we_reg <= 1'b0;
      current_pc_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      current_pc_reg <= current_pc_i;
      if (bubble_next) begin
        wr_reg         <= 5'd0;
        regfile_we_reg <= 1'b0;
      end else begin
        wb_data_reg    <= wb_mux;
        wr_reg         <= wr_i;
        regfile_we_reg <= regfile_we_i;
      end
    end
  end

  assign wb_data_o    = wb_data_reg;
  assign wr_o         = wr_reg;
  assign regfile_we_o = regfile_we_reg;
  assign current_pc_o = current_pc_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed instructions feed expected queues; a monitor
// checks memory strobes and MEM/WB writebacks as the DUT presents them.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result, mem_wd, return_pc, current_pc;
  logic        mem_we, regfile_we, is_sb;
  logic [1:0]  mem_data_sel, wd_sel;
  logic [4:0]  wr;
  logic        stall_o, dmem_re_o, dmem_we_o, regfile_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata, wb_data_o, current_pc_o;
  logic [4:0]  wr_o;

  int total = 0;
  int bad = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] data; logic [4:0] wr; logic [31:0] pc;} wb_t;
  logic [31:0] rq[$];
  wr_t         wq[$];
  wb_t         wbq[$];

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alu_result_i(alu_result), .mem_wd_i(mem_wd), .mem_we_i(mem_we),
    .mem_data_sel_i(mem_data_sel), .wr_i(wr), .wd_sel_i(wd_sel),
    .regfile_we_i(regfile_we), .return_pc_i(return_pc), .current_pc_i(current_pc),
    .is_sb_i(is_sb), .stall_o(stall_o), .dmem_addr_o(dmem_addr_o),
    .dmem_re_o(dmem_re_o), .dmem_we_o(dmem_we_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata), .wb_data_o(wb_data_o), .wr_o(wr_o),
    .regfile_we_o(regfile_we_o), .current_pc_o(current_pc_o)
  );

  // Word memory with 1-cycle read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h80FF_1234;
    mem[65] = 32'h5566_7788;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (dmem_re_o) dmem_rdata <= mem[dmem_addr_o[9:2]];
      if (dmem_we_o) mem[dmem_addr_o[9:2]] = dmem_wdata_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected strobes and writebacks whenever the DUT shows them
  initial begin
    logic  prev_we;
    logic [31:0] ra;
    wr_t   w;
    wb_t   b;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      check("strobe_overlap", {31'h0, dmem_re_o & dmem_we_o}, 32'h0);
      if (dmem_re_o) begin
        if (rq.size() == 0) check("unexpected_read", dmem_addr_o, 32'hFFFF_FFFF);
        else begin
          ra = rq.pop_front();
          check("rd_addr", dmem_addr_o, ra);
          $display("txn read  addr=%h", dmem_addr_o);
        end
      end
      if (dmem_we_o) begin
        if (wq.size() == 0) check("unexpected_write", dmem_addr_o, 32'hFFFF_FFFF);
        else begin
          w = wq.pop_front();
          check("wr_addr", dmem_addr_o, w.addr);
          check("wr_data", dmem_wdata_o, w.data);
          $display("txn write addr=%h data=%h", dmem_addr_o, dmem_wdata_o);
        end
      end
      if (regfile_we_o && !prev_we) begin
        if (wbq.size() == 0) check("unexpected_wb", wb_data_o, 32'hFFFF_FFFF);
        else begin
          b = wbq.pop_front();
          check("wb_data", wb_data_o, b.data);
          check("wb_wr", {27'h0, wr_o}, {27'h0, b.wr});
          check("wb_pc", current_pc_o, b.pc);
          $display("txn wb    rd=%0d data=%h pc=%h", wr_o, wb_data_o, current_pc_o);
        end
      end
      prev_we = regfile_we_o;
    end
  end

  // Drive one instruction (at posedge+1) and hold it until the DUT stops stalling.
  task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] wd,
                       input logic we, input logic sb, input logic [1:0] dsel,
                       input logic [1:0] wsel, input logic [4:0] rd, input logic rwe,
                       input logic [31:0] rpc, input int exp_stall);
    int   cnt, n;
    logic s;
    alu_result = alu; mem_wd = wd; mem_we = we; is_sb = sb; mem_data_sel = dsel;
    wd_sel = wsel; wr = rd; regfile_we = rwe; return_pc = rpc; current_pc = pc_ctr;
    cnt = 0; n = 0;
    do begin
      @(negedge clk);
      s = stall_o;
      if (s) cnt++;
      n++;
      @(posedge clk);
      #1;
    end while (s && n < 8);
    check({name, "_stall_cycles"}, cnt, exp_stall);
    check({name, "_wb_we"}, {31'h0, regfile_we_o}, {31'h0, rwe});
    pc_ctr += 32'd4;
  endtask

  task automatic nop();
    issue("nop", 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 1'b0, 32'h0, 0);
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] dsel,
                         input logic [4:0] rd, input logic [31:0] exp);
    rq.push_back({addr[31:2], 2'b00});
    wbq.push_back('{exp, rd, pc_ctr});
    issue(name, addr, 32'h0, 1'b0, 1'b0, dsel, 2'b01, rd, 1'b1, 32'h0, 1);
    nop();
  endtask

  task automatic do_sw(input logic [31:0] addr, input logic [31:0] data);
    wq.push_back('{{addr[31:2], 2'b00}, data});
    issue("sw", addr, data, 1'b1, 1'b0, 2'b00, 2'b00, 5'd0, 1'b0, 32'h0, 0);
    nop();
  endtask

  task automatic do_sb(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] merged);
    rq.push_back({addr[31:2], 2'b00});
    wq.push_back('{{addr[31:2], 2'b00}, merged});
    issue("sb", addr, wd, 1'b1, 1'b1, 2'b00, 2'b00, 5'd0, 1'b0, 32'h0, 1);
    nop();
  endtask

  task automatic do_wb(input string name, input logic [1:0] wsel, input logic [31:0] alu,
                       input logic [31:0] rpc, input logic [4:0] rd, input logic [31:0] exp);
    wbq.push_back('{exp, rd, pc_ctr});
    issue(name, alu, 32'h0, 1'b0, 1'b0, 2'b00, wsel, rd, 1'b1, rpc, 0);
    nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alu_result = 32'h100; mem_wd = 32'h1234_5678; mem_we = 1'b1; is_sb = 1'b0;
    mem_data_sel = 2'b00; wd_sel = 2'b00; wr = 5'd3; regfile_we = 1'b1;
    return_pc = 32'h0; current_pc = 32'h0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_dmem_we", {31'h0, dmem_we_o}, 32'h0);
      check("rst_regfile_we", {31'h0, regfile_we_o}, 32'h0);
      check("rst_wb_data", wb_data_o, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_load("lb",     32'h103, 2'b01, 5'd5, 32'hFFFF_FF80);
    do_load("lbu",    32'h103, 2'b10, 5'd6, 32'h0000_0080);
    do_load("lh_hi",  32'h102, 2'b11, 5'd7, 32'hFFFF_80FF);
    do_load("lw_off", 32'h101, 2'b00, 5'd8, 32'h80FF_1234);
    do_load("lh_lo",  32'h100, 2'b11, 5'd9, 32'h0000_1234);
    do_sw(32'h100, 32'hDEAD_BEEF);
    do_load("lw_sw",  32'h100, 2'b00, 5'd10, 32'hDEAD_BEEF);
    do_sw(32'h100, 32'h1122_3344);
    do_sb(32'h101, 32'h1234_56AB, 32'h1122_AB44);
    do_load("lw_sb",  32'h100, 2'b00, 5'd11, 32'h1122_AB44);
    do_wb("jal", 2'b10, 32'h0000_0200, 32'h0000_0044, 5'd1, 32'h0000_0044);
    do_wb("alu00", 2'b00, 32'hCAFE_F00D, 32'h0000_0088, 5'd3, 32'hCAFE_F00D);
    do_wb("alu11", 2'b11, 32'h1357_9BDF, 32'h0000_0088, 5'd4, 32'h1357_9BDF);

    // Reset while in SB_MERGE: the read happens, the write must not.
    rq.push_back(32'h104);
    alu_result = 32'h107; mem_wd = 32'h0000_00EE; mem_we = 1'b1; is_sb = 1'b1;
    wd_sel = 2'b00; wr = 5'd0; regfile_we = 1'b0; current_pc = pc_ctr;
    @(negedge clk);
    check("rstmid_stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_dmem_we", {31'h0, dmem_we_o}, 32'h0);
    check("rstmid_stall_low", {31'h0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid_wb_data", wb_data_o, 32'h0);
    check("rstmid_pc", current_pc_o, 32'h0);
    check("rstmid_mem_word", mem[65], 32'h5566_7788);
    nop();
    do_load("lw_after_rst", 32'h104, 2'b00, 5'd12, 32'h5566_7788);

    repeat (3) @(posedge clk);
    check("rq_drained", rq.size(), 32'h0);
    check("wq_drained", wq.size(), 32'h0);
    check("wbq_drained", wbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
